// File: rtl/cell_grid_renderer_pkg.sv
// Shared geometry, colour levels and pipeline sideband type for the cell-grid renderer.
package cell_grid_renderer_pkg;

  localparam int unsigned CoordW       = 11;
  localparam int unsigned VgaW         = 640;
  localparam int unsigned VgaH         = 480;
  localparam int unsigned DefCellShift = 3;
  localparam int unsigned DefGridW     = 64;
  localparam int unsigned DefGridH     = 48;

  typedef enum logic [2:0] {
    PixBlank,
    PixBorder,
    PixCursor,
    PixGrid,
    PixAlive,
    PixDead
  } pix_e;

  // Per-pixel state carried from stage A to stage B alongside the memory read.
  typedef struct packed {
    logic       valid;
    logic       candraw;
    logic       in_grid;
    logic [2:0] bit_idx;
    logic       cur_vis;
    logic       line_hit;
    logic       grid_en;
    logic       invert;
  } side_t;

  function automatic int unsigned color_border(int unsigned cw);
    return 32'd1 << (cw - 32'd3);
  endfunction

  function automatic int unsigned color_grid(int unsigned cw);
    return 32'd1 << (cw - 32'd4);
  endfunction

endpackage

// File: rtl/cell_grid_renderer_pipe_delay.sv
// Width x Depth shift register; synchronous reset clears every stage.
module cell_grid_renderer_pipe_delay #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/cell_grid_renderer.sv
// Pixel renderer: maps x/y to a cell, fetches its packed byte and emits RGB plus blank,
// with a latency of MEM_LAT + 2 cycles.
module cell_grid_renderer
  import cell_grid_renderer_pkg::*;
#(
  parameter int unsigned CELL_SHIFT   = DefCellShift,
  parameter int unsigned GRID_W       = DefGridW,
  parameter int unsigned GRID_H       = DefGridH,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned COLOR_W      = 10,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               candraw,
  input  logic [10:0]        x,
  input  logic [10:0]        y,
  input  logic [10:0]        cursor_x,
  input  logic [10:0]        cursor_y,
  input  logic               grid_en,
  input  logic               invert,
  input  logic [7:0]         data,
  output logic [ADDR_W-1:0]  addr,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               vga_blank
);

  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [COLOR_W-1:0] ColorMax    = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] ColorBorder = COLOR_W'(color_border(COLOR_W));
  localparam logic [COLOR_W-1:0] ColorGrid   = COLOR_W'(color_grid(COLOR_W));
  localparam logic [COLOR_W-1:0] ColorCursor = ColorMax;

  // Stage A
  logic [CoordW-1:0] col, row;
  logic              in_grid, cur_hit, line_hit, frame_start;
  logic [ADDR_W-1:0] addr_d, addr_q;
  side_t             side_d, side_q, side_dly;
  logic [BlinkW-1:0] blink_cnt_d, blink_cnt_q;
  logic              phase_d, phase_q;

  always_comb begin
    col      = x >> CELL_SHIFT;
    row      = y >> CELL_SHIFT;
    in_grid  = candraw && (col < CoordW'(GRID_W)) && (row < CoordW'(GRID_H));
    cur_hit  = (col == cursor_x) && (row == cursor_y);
    line_hit = (x[CELL_SHIFT-1:0] == '0) || (y[CELL_SHIFT-1:0] == '0);
    // GRID_W is a multiple of 8, so the byte index splits cleanly into row and column parts.
    addr_d   = in_grid ? ADDR_W'(row) * ADDR_W'(GRID_W / 8) + ADDR_W'(col >> 3) : '0;

    side_d          = '0;
    side_d.valid    = 1'b1;
    side_d.candraw  = candraw;
    side_d.in_grid  = in_grid;
    side_d.bit_idx  = col[2:0];
    side_d.cur_vis  = cur_hit && phase_q;
    side_d.line_hit = line_hit;
    side_d.grid_en  = grid_en;
    side_d.invert   = invert;
  end

  always_comb begin
    frame_start = candraw && (x == '0) && (y == '0);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      side_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      addr_q      <= addr_d;
      side_q      <= side_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign addr = addr_q;

  cell_grid_renderer_pipe_delay #(
    .Width($bits(side_t)),
    .Depth(MEM_LAT)
  ) u_side_delay (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (side_q),
    .q_o   (side_dly)
  );

  // Stage B
  logic               alive;
  pix_e               pix;
  logic [COLOR_W-1:0] red_d, green_d, blue_d, red_q, green_q, blue_q;
  logic               blank_d, blank_q;

  always_comb begin
    alive = data[side_dly.bit_idx] ^ side_dly.invert;
    pix   = PixDead;
    if (!(side_dly.valid && side_dly.candraw)) begin
      pix = PixBlank;
    end else if (!side_dly.in_grid) begin
      pix = PixBorder;
    end else if (side_dly.cur_vis) begin
      pix = PixCursor;
    end else if (side_dly.grid_en && side_dly.line_hit) begin
      pix = PixGrid;
    end else if (alive) begin
      pix = PixAlive;
    end
  end

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    blank_d = 1'b0;
    case (pix)
      PixBlank:  blank_d = 1'b1;
      PixBorder: begin
        red_d   = ColorBorder;
        green_d = ColorBorder;
        blue_d  = ColorBorder;
      end
      PixCursor: red_d = ColorCursor;
      PixGrid: begin
        red_d   = ColorGrid;
        green_d = ColorGrid;
        blue_d  = ColorGrid;
      end
      PixAlive: begin
        red_d   = ColorMax;
        green_d = ColorMax;
        blue_d  = ColorMax;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      blank_q <= 1'b1;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      blank_q <= blank_d;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign vga_blank = blank_q;

endmodule

// File: tb/tb_cell_grid_renderer.sv
// Randomised bench comparing the renderer against a per-pixel reference model.
module tb_cell_grid_renderer;

  localparam int CS = 3;
  localparam int GW = 64;
  localparam int GH = 48;
  localparam int AW = 11;
  localparam int ML = 1;
  localparam int CW = 10;
  localparam int BF = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst_n, candraw, grid_en, invert, vga_blank;
  logic [10:0]   x, y, cursor_x, cursor_y;
  logic [7:0]    data;
  logic [AW-1:0] addr;
  logic [CW-1:0] red, green, blue;

  cell_grid_renderer #(
    .CELL_SHIFT(CS), .GRID_W(GW), .GRID_H(GH), .ADDR_W(AW),
    .MEM_LAT(ML), .COLOR_W(CW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .candraw(candraw), .x(x), .y(y),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .grid_en(grid_en), .invert(invert),
    .data(data), .addr(addr), .red(red), .green(green), .blue(blue), .vga_blank(vga_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell memory with MEM_LAT cycles of read latency.
  logic [7:0] mem [2**AW];
  logic [7:0] rd_pipe [ML];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[addr];
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign data = rd_pipe[ML-1];

  typedef struct {
    logic [CW-1:0] r, g, b;
    logic          blank;
  } exp_t;

  bit   cells [GH][GW];
  exp_t exp_q [$];
  int   blink_cnt;
  bit   phase;
  int   n_cmp, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_pixel(logic cd, int px, int py);
    exp_t e;
    int col, row;
    bit in_grid;
    e.r = '0; e.g = '0; e.b = '0; e.blank = 1'b0;
    col = px >> CS;
    row = py >> CS;
    in_grid = cd && col < GW && row < GH;
    if (!cd) begin
      e.blank = 1'b1;
    end else if (!in_grid) begin
      e.r = CW'(1 << (CW - 3)); e.g = e.r; e.b = e.r;
    end else if (col == int'(cursor_x) && row == int'(cursor_y) && phase) begin
      e.r = CW'(CMAX);
    end else if (grid_en && ((px % (1 << CS)) == 0 || (py % (1 << CS)) == 0)) begin
      e.r = CW'(1 << (CW - 4)); e.g = e.r; e.b = e.r;
    end else if (cells[row][col] ^ invert) begin
      e.r = CW'(CMAX); e.g = e.r; e.b = e.r;
    end
    return e;
  endfunction

  task automatic drive_pixel(input logic cd, input int px, input int py);
    exp_t e, o;
    int col, row, exp_addr;
    candraw = cd;
    x = 11'(px);
    y = 11'(py);
    e = model_pixel(cd, px, py);
    col = px >> CS;
    row = py >> CS;
    exp_addr = (cd && col < GW && row < GH) ? (row * GW + col) / 8 : 0;
    if (cd && px == 0 && py == 0) begin
      if (blink_cnt == BF - 1) begin
        blink_cnt = 0;
        phase = !phase;
      end else begin
        blink_cnt++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq("addr", 32'(addr), 32'(exp_addr));
    if (exp_q.size() > ML + 1) begin
      o = exp_q.pop_front();
      check_eq("red", 32'(red), 32'(o.r));
      check_eq("green", 32'(green), 32'(o.g));
      check_eq("blue", 32'(blue), 32'(o.b));
      check_eq("vga_blank", 32'(vga_blank), 32'(o.blank));
    end
  endtask

  task automatic do_reset(input int cycles);
    exp_t b;
    rst_n = 1'b0;
    candraw = 1'($urandom);
    x = 11'($urandom_range(0, 600));
    y = 11'($urandom_range(0, 400));
    repeat (cycles) @(posedge clk);
    #1;
    check_eq("rst_blank", 32'(vga_blank), 32'd1);
    check_eq("rst_rgb", {2'b0, red, green, blue}, 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    blink_cnt = 0;
    phase = 1'b1;
    exp_q.delete();
    b.r = '0; b.g = '0; b.b = '0; b.blank = 1'b1;
    for (int i = 0; i < ML + 1; i++) exp_q.push_back(b);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) cells[r][c] = 1'($urandom);
    cells[1][2] = 1'b1;
    cells[1][3] = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) mem[(r * GW + c) / 8][c % 8] = cells[r][c];

    rst_n = 1'b0; candraw = 1'b0; x = '0; y = '0;
    cursor_x = 11'd100; cursor_y = 11'd100; grid_en = 1'b0; invert = 1'b0;

    // Reset, then idle with candraw low.
    do_reset(3);
    repeat (3) drive_pixel(1'b0, 5, 5);

    // Alive cell (col 2, row 1), then inverted.
    drive_pixel(1'b1, 17, 9);
    invert = 1'b1;
    drive_pixel(1'b1, 17, 9);
    invert = 1'b0;

    // Border and grid-edge boundaries.
    drive_pixel(1'b1, 512, 0);
    drive_pixel(1'b1, 511, 383);
    drive_pixel(1'b1, 504, 9);
    drive_pixel(1'b1, 17, 384);

    // Grid lines over a dead cell.
    grid_en = 1'b1;
    drive_pixel(1'b1, 24, 13);
    grid_en = 1'b0;
    drive_pixel(1'b1, 24, 13);

    // Cursor blink over four frames.
    cursor_x = 11'd3; cursor_y = 11'd1;
    for (int f = 0; f < 4; f++) begin
      drive_pixel(1'b1, 24, 9);
      drive_pixel(1'b1, 0, 0);
    end

    // Cursor outside the grid is never drawn.
    cursor_x = 11'd64; cursor_y = 11'd1;
    drive_pixel(1'b1, 515, 9);

    // Reset with the pipeline full, then resume.
    for (int i = 0; i < 4; i++) drive_pixel(1'b1, 8 * i + 1, 10);
    do_reset(1);
    for (int i = 0; i < 5; i++) drive_pixel(1'b1, 8 * i + 3, 17);

    // Randomised pixels.
    for (int n = 0; n < 2000; n++) begin
      int px, py;
      px = $urandom_range(0, 600);
      py = $urandom_range(0, 420);
      if ($urandom_range(0, 7) == 0) begin
        px = 0;
        py = 0;
      end
      if ($urandom_range(0, 3) == 0) begin
        cursor_x = 11'(px >> CS);
        cursor_y = 11'(py >> CS);
      end else if ($urandom_range(0, 7) == 0) begin
        cursor_x = 11'($urandom_range(0, 70));
        cursor_y = 11'($urandom_range(0, 50));
      end
      grid_en = 1'($urandom);
      invert = 1'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset(1);
      drive_pixel(($urandom_range(0, 9) != 0), px, py);
    end

    for (int i = 0; i < ML + 1; i++) drive_pixel(1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cell_grid_renderer.md
Name: cell_grid_renderer

Overview:
- Parametrised pixel renderer for the Game of Life VGA path. It sits between the VGA timing generator (x, y, candraw) and the cell-state memory (addr/data).
- It maps each pixel to a cell, fetches the packed cell byte, and emits RGB and vga_blank.
- It adds over the first-generation renderer:
  - configurable cell size and grid dimensions
  - memory-latency compensation
  - a blinking cursor
  - optional grid lines and an invert mode

Parameters:
- CELL_SHIFT, 3, log2 of cell edge in pixels (cell = 8x8 px)
- GRID_W, 64, grid width in cells; must be a multiple of 8
- GRID_H, 48, grid height in cells
- ADDR_W, 11, memory address width; GRID_W*GRID_H/8 must be ≤ 2^ADDR_W
- MEM_LAT, 1, cycles from addr to valid data (≥1)
- COLOR_W, 10, bits per colour channel
- BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- candraw  in  1  pixel is in the visible area
- x  in  11  pixel column
- y  in  11  pixel row
- cursor_x  in  11  cursor cell column
- cursor_y  in  11  cursor cell row
- grid_en  in  1  draw grid lines
- invert  in  1  swap alive/dead colours
- data  in  8  cell byte from memory; bit i = cell column (8k+i)
- addr  out  ADDR_W  cell byte address (registered)
- red  out  COLOR_W  red channel
- green  out  COLOR_W  green channel
- blue  out  COLOR_W  blue channel
- vga_blank  out  1  high = blank (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: red = green = blue = 0, vga_blank = 1, addr = 0, every pipeline-stage valid bit = 0, blink counter = 0, blink phase = 1 (cursor visible).
- Stage A (cycle 0→1):
  - col = x >> CELL_SHIFT, row = y >> CELL_SHIFT.
  - in_grid = candraw && col < GRID_W && row < GRID_H.
  - addr <= in_grid ? (row*GRID_W + col) >> 3 : 0.
  - Sideband registered alongside: bit_idx = col[2:0], in_grid, candraw.
  - cur_hit = (col == cursor_x && row == cursor_y).
  - line_hit = (x[CELL_SHIFT-1:0] == 0 || y[CELL_SHIFT-1:0] == 0).
- Delay line: the sideband is delayed MEM_LAT cycles so it aligns with data.
- Stage B:
  - alive = data[bit_idx] ^ invert.
  - Colour is chosen in priority order; the first match wins:
    1. not candraw: RGB = 0, vga_blank = 1.
    2. not in_grid: border colour, all channels = 1 << (COLOR_W-3).
    3. cur_hit && blink phase: red = max, green = blue = 0.
    4. grid_en && line_hit: all channels = 1 << (COLOR_W-4).
    5. alive: all channels max.
    6. otherwise: all channels 0.
- Latency: exactly MEM_LAT + 2 cycles from x/y/candraw to RGB/vga_blank. vga_blank is delayed identically to RGB.
- Blink logic:
  - A frame start is stage-A candraw && x == 0 && y == 0.
  - On each frame start the counter increments.
  - When the counter equals BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - BLINK_FRAMES = 1 toggles the phase every frame.
- Boundary conditions:
  - Cursor outside the grid is never drawn, because rule 2 wins.
  - A cell-boundary pixel at col = GRID_W-1 is still in_grid.
  - x = GRID_W << CELL_SHIFT is border.
  - Out-of-grid pixels drive addr = 0; data returned for them is ignored.
- Reset mid-frame:
  - All valid bits clear, so outputs stay blank and zero for MEM_LAT + 2 cycles after rst_n rises.
  - The blink counter restarts from 0.
- Input changes: changing cursor_x/y, grid_en or invert takes effect on the next pixel sampled at stage A. grid_en and invert are sampled at stage A and carried through the pipeline, so there is no tearing within a pixel.

Decomposition:
- Shared package (defines.v):
  - colour constants: COLOR_MAX, COLOR_BORDER, COLOR_GRID, COLOR_CURSOR
  - default geometry: GRID_W, GRID_H, CELL_SHIFT
  - VGA width constants
- One natural sub-module, pipe_delay: a parametrised width × depth shift register carrying the sideband for MEM_LAT cycles.

Test Plan:
1. Reset, then rst_n = 1 with candraw = 0 → vga_blank = 1, RGB = 0, addr = 0.
2. Defaults, MEM_LAT = 1. x = 17, y = 9 (col 2, row 1), mem returns data = 8'b0000_0100 → addr = 8 one cycle later. White (0x3FF) with vga_blank = 0 appears exactly 3 cycles after input; with invert = 1 the output is black.
3. x = 512, y = 0 with candraw → addr = 0; after 3 cycles all channels = 0x080 (border).
4. grid_en = 1, x = 24, y = 13 in a dead cell → channels = 0x040. Same pixel with grid_en = 0 → 0.
5. cursor = (3, 1), BLINK_FRAMES = 2. Drive 4 frame starts and sample x = 24, y = 9 each frame → red = 0x3FF for frames 0–1, then the cell colour for frames 2–3.
6. Assert rst_n = 0 for one cycle mid-line with the pipeline full → the next 3 outputs are blank/0, then normal rendering resumes at the correct latency.
